ir_move_receiver: RTL and testbench
===================================

Name: ir_move_receiver

Overview:
- Rover-side counterpart to the base-station move-command transmitter.
- Decodes the demodulated IR pulse-width stream into 12-bit move commands: theta [11:8], distance [7:0].
- Executes each command as a timed move: turn, then a stall, then forward drive.
- Ignores the repeated frames the base station sends during its IR hold window while a move is in progress.

Parameters:
- UNIT_CYCLES, 16200: clock cycles per 600 us protocol unit at 27 MHz.
- MOVE_DELAY_FACTOR, 27000000: clock cycles per move step (1 s). One step = one theta unit or one distance unit.
- FRAME_BITS, 12: command bits per frame, sent LSB first.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset reset, synchronous, active-high; clock clock.
- ir_in  in  1  demodulated IR; 1 = carrier present. Asynchronous.
- turn_en  out  1  drive motors turning clockwise in place.
- fwd_en  out  1  drive motors forward.
- busy  out  1  a move is executing.
- frame_valid  out  1  one-cycle pulse on each good frame.
- frame_error  out  1  one-cycle pulse on each malformed frame.
- last_command  out  12  most recent good frame.

Behaviour:
- Reset: all outputs 0, last_command = 12'h000, both FSMs in IDLE, all counters 0.
- ir_in passes through a 2-flop synchronizer. Pulse widths are measured on the synchronized signal: +2 cycles input latency.
- Frame format:
  - start mark of 4 units (2.4 ms);
  - then FRAME_BITS marks, each followed by a 1-unit space;
  - a 2-unit mark = bit 1, a 1-unit mark = bit 0.
- Mark classification, on the falling edge of each mark (len = mark length in cycles):
  - len >= 3*UNIT: start;
  - len >= 3*UNIT/2: one;
  - len >= UNIT/2: zero;
  - shorter: glitch.
- Receive FSM:
  - RX_IDLE: a start mark -> RX_BITS, bit_count = 0. Any other mark is discarded silently.
  - RX_BITS:
    - one/zero: shift into bit position bit_count; bit_count++.
    - start: restart the frame, bit_count = 0, no error pulse.
    - glitch: frame_error pulse -> RX_IDLE.
    - space > 4*UNIT: frame_error pulse -> RX_IDLE.
    - bit_count reaching FRAME_BITS -> RX_DONE.
  - RX_DONE (1 cycle): frame_valid pulse, last_command updated, then -> RX_IDLE.
- Move FSM states: MV_IDLE, MV_TURN, MV_STALL, MV_FWD.
  - Start condition: frame_valid while in MV_IDLE with command != 12'h000. busy rises the next cycle.
  - Frames arriving while busy = 1 are decoded and update last_command, but are NOT executed and are not queued.
  - Command 12'h000 is never executed.
  - MV_TURN: turn_en = 1 for theta * MOVE_DELAY_FACTOR cycles. Skipped when theta = 0.
  - MV_STALL: both enables 0 for exactly 1 * MOVE_DELAY_FACTOR cycles. Always entered.
  - MV_FWD: fwd_en = 1 for distance * MOVE_DELAY_FACTOR cycles. Skipped when distance = 0.
  - The FSM then returns to MV_IDLE and busy falls.
- Total busy time = (theta + distance + 1) * MOVE_DELAY_FACTOR cycles ±1. This matches the base station's wait.
- Step timing uses an outer step counter (8 bits) and an inner counter (32 bits) that reloads at MOVE_DELAY_FACTOR. No multiplier.
- turn_en and fwd_en are never both 1.
- Reset mid-move: both enables drop to 0 on the same edge. The partial move is abandoned.
- Counter saturation: the mark counter saturates at 8*UNIT. The space counter saturates at 8*UNIT.

Optional Feature:
- MOVE_ECHO_EN:
  - Defined: a command executes only when two consecutive good frames carry identical values with no frame_error pulse between them. After a frame_error the pair must restart; after an execution, the next match requires two fresh frames.
  - Undefined: the first good frame executes.
- frame_valid and last_command behave identically in both builds.

Test Plan:
- Sim parameters: UNIT_CYCLES = 10, MOVE_DELAY_FACTOR = 100.
- Single frame 12'h305:
  - frame_valid pulses once; last_command = 12'h305;
  - turn_en high 300 cycles, stall 100, fwd_en high 500;
  - busy high 900 ±1 cycles.
- Command 12'h007: turn skipped, stall 100, fwd 700. Command 12'h000: frame_valid pulses, busy stays 0.
- Glitch mark of 3 cycles in the middle of bit 5: frame_error pulses once, no frame_valid, no move. The next clean frame decodes correctly.
- 5 identical 12'h10A frames back-to-back:
  - one move only (100 turn, 100 stall, 1000 fwd);
  - frame_valid pulses 5 times.
- Assert reset mid-MV_FWD: turn_en, fwd_en and busy are 0 on the next edge. A fresh frame 12'h001 then runs 100 stall + 100 fwd.
- With MOVE_ECHO_EN: frames 12'h204, 12'h205, 12'h205 -> move 12'h205 starts only after the third frame. Frames 12'h204, error, 12'h204 -> no move.

Source files
------------

// File: rtl/ir_move_receiver.sv
// IR move-command receiver: decodes pulse-width frames, runs timed moves.
// Build option: MOVE_ECHO_EN requires two matching frames to run a move.
module ir_move_receiver #(
  parameter int UNIT_CYCLES       = 16200,
  parameter int MOVE_DELAY_FACTOR = 27000000,
  parameter int FRAME_BITS        = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ir_in,
  output logic        turn_en,
  output logic        fwd_en,
  output logic        busy,
  output logic        frame_valid,
  output logic        frame_error,
  output logic [11:0] last_command
);

  localparam int CW = $clog2(8 * UNIT_CYCLES + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);

  localparam logic [CW-1:0] SAT_LEN   = CW'(8 * UNIT_CYCLES);
  localparam logic [CW-1:0] START_LEN = CW'(3 * UNIT_CYCLES);
  localparam logic [CW-1:0] ONE_LEN   = CW'(3 * UNIT_CYCLES / 2);
  localparam logic [CW-1:0] ZERO_LEN  = CW'(UNIT_CYCLES / 2);
  localparam logic [CW-1:0] SPACE_MAX = CW'(4 * UNIT_CYCLES);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS - 1);
  localparam logic [31:0]   TICK_LOAD = 32'(MOVE_DELAY_FACTOR - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_BITS,
    RX_DONE
  } rx_t;

  typedef enum logic [1:0] {
    MV_IDLE,
    MV_TURN,
    MV_STALL,
    MV_FWD
  } mv_t;

  logic                  sync1, sync2, sync3;
  logic                  fall;
  logic [CW-1:0]         mark_cnt, space_cnt;
  logic                  is_start, is_one, is_zero;

  rx_t                   rx_state, rx_next;
  logic [FRAME_BITS-1:0] bits, bits_next;
  logic [BW-1:0]         bit_count, cnt_next;

  mv_t                   mv_state, mv_next;
  logic [7:0]            step, step_next;
  logic [31:0]           tick, tick_next;
  logic [7:0]            move_dist, dist_next;
  logic                  echo_ok;
  logic                  exec;

  assign fall     = sync3 & ~sync2;
  assign is_start = mark_cnt >= START_LEN;
  assign is_one   = mark_cnt >= ONE_LEN;
  assign is_zero  = mark_cnt >= ZERO_LEN;

  // Two-flop synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= ir_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Saturating mark and space length counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      mark_cnt  <= '0;
      space_cnt <= '0;
    end else if (sync2) begin
      space_cnt <= '0;
      if (mark_cnt != SAT_LEN)
        mark_cnt <= mark_cnt + 1'b1;
    end else begin
      mark_cnt <= '0;
      if (space_cnt != SAT_LEN)
        space_cnt <= space_cnt + 1'b1;
    end
  end

  // Receive state, shift register and command latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state     <= RX_IDLE;
      bits         <= '0;
      bit_count    <= '0;
      last_command <= 12'h000;
    end else begin
      rx_state  <= rx_next;
      bits      <= bits_next;
      bit_count <= cnt_next;
      if (rx_state == RX_BITS && rx_next == RX_DONE)
        last_command <= 12'(bits_next);
    end
  end

  // Receive next-state: classify each mark on its falling edge.
  always_comb begin
    rx_next     = rx_state;
    bits_next   = bits;
    cnt_next    = bit_count;
    frame_valid = 1'b0;
    frame_error = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (fall && is_start) begin
          rx_next   = RX_BITS;
          bits_next = '0;
          cnt_next  = '0;
        end
      end
      RX_BITS: begin
        if (fall) begin
          if (is_start) begin
            bits_next = '0;
            cnt_next  = '0;
          end else if (is_zero) begin
            bits_next[bit_count] = is_one;
            cnt_next = bit_count + 1'b1;
            if (bit_count == LAST_BIT)
              rx_next = RX_DONE;
          end else begin
            frame_error = 1'b1;
            rx_next     = RX_IDLE;
          end
        end else if (!sync2 && space_cnt > SPACE_MAX) begin
          frame_error = 1'b1;
          rx_next     = RX_IDLE;
        end
      end
      RX_DONE: begin
        frame_valid = 1'b1;
        rx_next     = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

`ifdef MOVE_ECHO_EN
  logic        pair_valid;
  logic [11:0] pair_cmd;

  assign echo_ok = pair_valid && (pair_cmd == last_command);

  // Remember the previous good frame; errors and executions break the pair.
  always_ff @(posedge clock) begin
    if (reset) begin
      pair_valid <= 1'b0;
      pair_cmd   <= 12'h000;
    end else if (frame_error) begin
      pair_valid <= 1'b0;
    end else if (frame_valid) begin
      if (exec) begin
        pair_valid <= 1'b0;
      end else begin
        pair_valid <= 1'b1;
        pair_cmd   <= last_command;
      end
    end
  end
`else
  assign echo_ok = 1'b1;
`endif

  assign exec = frame_valid && (mv_state == MV_IDLE)
             && (last_command != 12'h000) && echo_ok;

  assign turn_en = (mv_state == MV_TURN);
  assign fwd_en  = (mv_state == MV_FWD);
  assign busy    = (mv_state != MV_IDLE);

  // Move state and step/tick counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      mv_state  <= MV_IDLE;
      step      <= 8'd0;
      tick      <= 32'd0;
      move_dist <= 8'd0;
    end else begin
      mv_state  <= mv_next;
      step      <= step_next;
      tick      <= tick_next;
      move_dist <= dist_next;
    end
  end

  // Move next-state: each phase lasts step * MOVE_DELAY_FACTOR cycles.
  always_comb begin
    mv_next   = mv_state;
    step_next = step;
    tick_next = tick;
    dist_next = move_dist;
    unique case (mv_state)
      MV_IDLE: begin
        if (exec) begin
          dist_next = last_command[7:0];
          tick_next = TICK_LOAD;
          step_next = 8'd1;
          mv_next   = MV_STALL;
          if (last_command[11:8] != 4'd0) begin
            mv_next   = MV_TURN;
            step_next = {4'd0, last_command[11:8]};
          end
        end
      end
      default: begin
        if (tick != 32'd0) begin
          tick_next = tick - 32'd1;
        end else if (step != 8'd1) begin
          step_next = step - 8'd1;
          tick_next = TICK_LOAD;
        end else if (mv_state == MV_TURN) begin
          mv_next   = MV_STALL;
          step_next = 8'd1;
          tick_next = TICK_LOAD;
        end else if (mv_state == MV_STALL
                     && move_dist != 8'd0) begin
          mv_next   = MV_FWD;
          step_next = move_dist;
          tick_next = TICK_LOAD;
        end else begin
          mv_next   = MV_IDLE;
          step_next = 8'd0;
          tick_next = 32'd0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_ir_move_receiver.sv
// Randomized self-checking bench for ir_move_receiver.
// Expected timings come from the command fields with plain arithmetic.
module tb_ir_move_receiver;

  localparam int UNIT = 10;
  localparam int MDF  = 100;

  logic        clock = 1'b0;
  logic        reset;
  logic        ir_in;
  logic        turn_en, fwd_en, busy;
  logic        frame_valid, frame_error;
  logic [11:0] last_command;

  int total = 0;
  int bad   = 0;

  int cyc = 0, fv_n = 0, fe_n = 0, turn_n = 0, fwd_n = 0;
  int busy_n = 0, stall_n = 0, rise_n = 0, ovl_n = 0;
  logic        busy_q = 1'b0;
  logic [11:0] fv_cmd = 12'h000;

  ir_move_receiver #(
    .UNIT_CYCLES(UNIT),
    .MOVE_DELAY_FACTOR(MDF),
    .FRAME_BITS(12)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ir_in(ir_in),
    .turn_en(turn_en),
    .fwd_en(fwd_en),
    .busy(busy),
    .frame_valid(frame_valid),
    .frame_error(frame_error),
    .last_command(last_command)
  );

  always #5 clock = ~clock;

  // Activity monitor sampled away from the active edge.
  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (frame_valid) begin
      fv_n   <= fv_n + 1;
      fv_cmd <= last_command;
    end
    if (frame_error) fe_n <= fe_n + 1;
    if (turn_en) turn_n <= turn_n + 1;
    if (fwd_en) fwd_n <= fwd_n + 1;
    if (busy) busy_n <= busy_n + 1;
    if (busy && !turn_en && !fwd_en) stall_n <= stall_n + 1;
    if (busy && !busy_q) rise_n <= rise_n + 1;
    if (turn_en && fwd_en) ovl_n <= ovl_n + 1;
    busy_q <= busy;
  end

  task automatic gap(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic mark(input int n);
    ir_in = 1'b1;
    repeat (n) @(negedge clock);
    ir_in = 1'b0;
  endtask

  task automatic send_frame(input logic [11:0] c, input int glitch);
    mark(4 * UNIT);
    gap(UNIT);
    for (int i = 0; i < 12; i++) begin
      if (i == glitch) mark(3);
      else mark(c[i] ? 2 * UNIT : UNIT);
      gap(UNIT);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 5000) begin
      @(negedge clock);
      k++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL %s idle: busy=%b after %0d cycles, required 0",
               tag, busy, k);
    end
    gap(3);
  endtask

  // Sends one frame, waits for any move to end, returns activity deltas.
  task automatic measure(input logic [11:0] c, input string tag,
                         output int dfv, output int dturn,
                         output int dstall, output int dfwd,
                         output int dbusy, output int drise);
    int a_fv, a_t, a_s, a_f, a_b, a_r;
    a_fv = fv_n; a_t = turn_n; a_s = stall_n;
    a_f = fwd_n; a_b = busy_n; a_r = rise_n;
    send_frame(c, -1);
    wait_idle(tag);
    dfv = fv_n - a_fv; dturn = turn_n - a_t;
    dstall = stall_n - a_s; dfwd = fwd_n - a_f;
    dbusy = busy_n - a_b; drise = rise_n - a_r;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ir_in = 1'b0;
    gap(4);
    total += 6;
    if (turn_en !== 1'b0) begin bad++;
      $display("FAIL rst_turn: got %b want 0", turn_en); end
    if (fwd_en !== 1'b0) begin bad++;
      $display("FAIL rst_fwd: got %b want 0", fwd_en); end
    if (busy !== 1'b0) begin bad++;
      $display("FAIL rst_busy: got %b want 0", busy); end
    if (frame_valid !== 1'b0) begin bad++;
      $display("FAIL rst_fv: got %b want 0", frame_valid); end
    if (frame_error !== 1'b0) begin bad++;
      $display("FAIL rst_fe: got %b want 0", frame_error); end
    if (last_command !== 12'h000) begin bad++;
      $display("FAIL rst_cmd: got %h want 000", last_command); end
    reset = 1'b0;
    gap(20);
  endtask

  // Full move check of one command against field-derived durations.
  task automatic test_command(input logic [11:0] c, input string tag);
    int dfv, dt, ds, df, db, dr, th, d, run, eb, ov0;
    ov0 = ovl_n;
    measure(c, tag, dfv, dt, ds, df, db, dr);
    th = int'(c[11:8]); d = int'(c[7:0]);
    run = (c != 12'h000) ? 1 : 0;
    eb = run * (th + d + 1) * MDF;
    total += 8;
    if (dfv !== 1) begin bad++;
      $display("FAIL %s fv: got %0d want 1", tag, dfv); end
    if (fv_cmd !== c) begin bad++;
      $display("FAIL %s cmd: got %h want %h", tag, fv_cmd, c); end
    if (dr !== run) begin bad++;
      $display("FAIL %s moves: got %0d want %0d", tag, dr, run); end
    if (dt !== run * th * MDF) begin bad++;
      $display("FAIL %s turn: got %0d want %0d", tag, dt, run * th * MDF); end
    if (ds !== run * MDF) begin bad++;
      $display("FAIL %s stall: got %0d want %0d", tag, ds, run * MDF); end
    if (df !== run * d * MDF) begin bad++;
      $display("FAIL %s fwd: got %0d want %0d", tag, df, run * d * MDF); end
    if (db < eb - 1 || db > eb + 1) begin bad++;
      $display("FAIL %s busy: got %0d want %0d+-1", tag, db, eb); end
    if (ovl_n !== ov0) begin bad++;
      $display("FAIL %s overlap: got %0d want 0", tag, ovl_n - ov0); end
  endtask

  task automatic test_glitch();
    int a_fe, a_fv, a_r;
    a_fe = fe_n; a_fv = fv_n; a_r = rise_n;
    send_frame(12'h0A5, 5);
    gap(60);
    total += 3;
    if (fe_n - a_fe !== 1) begin bad++;
      $display("FAIL glitch fe: got %0d want 1", fe_n - a_fe); end
    if (fv_n - a_fv !== 0) begin bad++;
      $display("FAIL glitch fv: got %0d want 0", fv_n - a_fv); end
    if (rise_n - a_r !== 0) begin bad++;
      $display("FAIL glitch move: got %0d want 0", rise_n - a_r); end
    test_command(12'h102, "after_glitch");
  endtask

  // Frames arriving while the model says a move runs must not start one.
  task automatic test_back_to_back();
    int a_fv, a_t, a_f, a_r, idle_at, exp_r;
    a_fv = fv_n; a_t = turn_n; a_f = fwd_n; a_r = rise_n;
    idle_at = 0;
    exp_r = 0;
    for (int i = 0; i < 5; i++) begin
      send_frame(12'h10A, -1);
      if (cyc >= idle_at) begin
        exp_r++;
        idle_at = cyc + (1 + 10 + 1) * MDF;
      end
    end
    wait_idle("b2b");
    total += 4;
    if (fv_n - a_fv !== 5) begin bad++;
      $display("FAIL b2b fv: got %0d want 5", fv_n - a_fv); end
    if (rise_n - a_r !== exp_r) begin bad++;
      $display("FAIL b2b moves: got %0d want %0d", rise_n - a_r, exp_r); end
    if (turn_n - a_t !== exp_r * MDF) begin bad++;
      $display("FAIL b2b turn: got %0d want %0d", turn_n - a_t, exp_r * MDF); end
    if (fwd_n - a_f !== exp_r * 10 * MDF) begin bad++;
      $display("FAIL b2b fwd: got %0d want %0d",
               fwd_n - a_f, exp_r * 10 * MDF); end
  endtask

  task automatic test_reset_mid_move();
    int k = 0;
    send_frame(12'h102, -1);
    while (!fwd_en && k < 1000) begin
      @(negedge clock);
      k++;
    end
    total++;
    if (fwd_en !== 1'b1) begin bad++;
      $display("FAIL midrst reach_fwd: got %b want 1", fwd_en); end
    gap(50);
    reset = 1'b1;
    @(posedge clock);
    #1;
    total += 4;
    if (turn_en !== 1'b0) begin bad++;
      $display("FAIL midrst turn: got %b want 0", turn_en); end
    if (fwd_en !== 1'b0) begin bad++;
      $display("FAIL midrst fwd: got %b want 0", fwd_en); end
    if (busy !== 1'b0) begin bad++;
      $display("FAIL midrst busy: got %b want 0", busy); end
    if (last_command !== 12'h000) begin bad++;
      $display("FAIL midrst cmd: got %h want 000", last_command); end
    gap(2);
    reset = 1'b0;
    gap(20);
    test_command(12'h001, "post_reset");
  endtask

  task automatic test_random();
    logic [11:0] c;
    for (int i = 0; i < 5; i++) begin
      c = {4'($urandom_range(0, 3)), 8'($urandom_range(0, 6))};
      test_command(c, "random");
    end
  endtask

`ifdef MOVE_ECHO_EN
  task automatic test_echo();
    int a_r, a_fe;
    a_r = rise_n;
    send_frame(12'h204, -1);
    send_frame(12'h205, -1);
    total++;
    if (rise_n - a_r !== 0) begin bad++;
      $display("FAIL echo early: got %0d want 0", rise_n - a_r); end
    send_frame(12'h205, -1);
    total++;
    if (busy !== 1'b1) begin bad++;
      $display("FAIL echo start: got %b want 1", busy); end
    wait_idle("echo");
    a_r = rise_n; a_fe = fe_n;
    send_frame(12'h204, -1);
    send_frame(12'h204, 3);
    gap(60);
    send_frame(12'h204, -1);
    gap(20);
    total += 2;
    if (rise_n - a_r !== 0) begin bad++;
      $display("FAIL echo broken: got %0d want 0", rise_n - a_r); end
    if (fe_n - a_fe !== 1) begin bad++;
      $display("FAIL echo fe: got %0d want 1", fe_n - a_fe); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef MOVE_ECHO_EN
    test_echo();
`else
    test_command(12'h305, "single");
    test_command(12'h007, "no_turn");
    test_command(12'h000, "zero");
    test_glitch();
    test_back_to_back();
    test_reset_mid_move();
    test_random();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
